// File: rtl/demux32_1to2_fifo_pkg.sv
// Shared constants for the 1-to-2 demultiplexer: default sizes and destination encodings.
package demux32_1to2_fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux32_1to2_fifo_if.sv
// Producer-side and consumer-side handshake bundle of the 1-to-2 demultiplexer.
interface demux32_1to2_fifo_if
  import demux32_1to2_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] inData;
  logic             inValid;
  logic             sel;
  logic             inReady;
  logic [WIDTH-1:0] outA;
  logic             outAValid;
  logic             outAReady;
  logic [WIDTH-1:0] outB;
  logic             outBValid;
  logic             outBReady;
  logic [CW-1:0]    countA;
  logic [CW-1:0]    countB;

  // Environment side: producer and both consumers.
  modport master (
    output inData, inValid, sel, outAReady, outBReady,
    input  inReady, outA, outAValid, outB, outBValid, countA, countB
  );

  // Demultiplexer side.
  modport slave (
    input  inData, inValid, sel, outAReady, outBReady,
    output inReady, outA, outAValid, outB, outBValid, countA, countB
  );

endinterface

// File: rtl/demux32_1to2_fifo_sync_fifo_hs.sv
// Small synchronous FIFO with occupancy counter; head word is visible without a read strobe.
module sync_fifo_hs
  import demux32_1to2_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  output logic             full,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrptr;
  logic [AW-1:0]    rdptr;
  logic             do_wr;
  logic             do_rd;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign do_wr  = wrEn && !full;
  assign do_rd  = rdEn && !empty;
  assign rdData = mem[rdptr];

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        mem[wrptr] <= wrData;
        wrptr      <= wrptr + 1'b1;
      end
      if (do_rd) rdptr <= rdptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux32_1to2_fifo.sv
// Handshaked 1-to-2 demultiplexer: steers each accepted word into the FIFO of its
// destination so a stalled consumer never blocks the other one.
module demux32_1to2_fifo
  import demux32_1to2_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic                Clk,
  input logic                Rst_n,
  demux32_1to2_fifo_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);

  logic          full_a;
  logic          full_b;
  logic          empty_a;
  logic          empty_b;
  logic          push;
  logic [CW-1:0] count_a;
  logic [CW-1:0] count_b;

  // Readiness looks only at the addressed FIFO; a same-cycle pop does not free a full one.
  assign bus.inReady = (bus.sel == SEL_B) ? !full_b : !full_a;
  assign push        = bus.inValid && bus.inReady;

  assign bus.outAValid = !empty_a;
  assign bus.outBValid = !empty_b;
  assign bus.countA    = count_a;
  assign bus.countB    = count_b;

  sync_fifo_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .wrEn   (push && (bus.sel == SEL_A)),
    .wrData (bus.inData),
    .full   (full_a),
    .rdEn   (bus.outAReady),
    .rdData (bus.outA),
    .empty  (empty_a),
    .count  (count_a)
  );

  sync_fifo_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .wrEn   (push && (bus.sel == SEL_B)),
    .wrData (bus.inData),
    .full   (full_b),
    .rdEn   (bus.outBReady),
    .rdData (bus.outB),
    .empty  (empty_b),
    .count  (count_b)
  );

endmodule

// File: tb/tb_demux32_1to2_fifo.sv
// Testbench for the 1-to-2 demultiplexer: directed steps plus a randomized phase,
// all checked against a queue-based reference model.
module tb_demux32_1to2_fifo;
  import demux32_1to2_fifo_pkg::*;

  localparam int W = 32;
  localparam int D = 2;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;

  demux32_1to2_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  demux32_1to2_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Reference model: one queue per destination.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] popped_a[$];

  // Producer-rule tracking.
  logic         stalled   = 1'b0;
  logic [W-1:0] held_data = '0;
  logic         held_sel  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic exp_rdy;
    exp_rdy = bus.sel ? (qb.size() < D) : (qa.size() < D);
    chk("in_ready", bus.inReady, exp_rdy);
    chk("a_valid", bus.outAValid, qa.size() != 0);
    chk("b_valid", bus.outBValid, qb.size() != 0);
    chk("count_a", bus.countA, qa.size());
    chk("count_b", bus.countB, qb.size());
    if (qa.size() != 0) chk("out_a", bus.outA, qa[0]);
    if (qb.size() != 0) chk("out_b", bus.outB, qb[0]);
    if (stalled) begin
      chk("hold_data", bus.inData, held_data);
      chk("hold_sel", bus.sel, held_sel);
    end
  endtask

  // One clock: check pre-edge outputs, advance the model by the edge, return at negedge.
  task automatic tick();
    logic         push_ok, pop_a, pop_b, s;
    logic [W-1:0] dat;
    #1;
    check_state();
    s       = bus.sel;
    dat     = bus.inData;
    push_ok = bus.inValid && (s ? (qb.size() < D) : (qa.size() < D));
    pop_a   = bus.outAReady && (qa.size() != 0);
    pop_b   = bus.outBReady && (qb.size() != 0);
    if (pop_a) popped_a.push_back(bus.outA);
    stalled   = bus.inValid && !push_ok;
    held_data = dat;
    held_sel  = s;
    @(posedge Clk);
    if (pop_a) void'(qa.pop_front());
    if (pop_b) void'(qb.pop_front());
    if (push_ok) begin
      if (s) qb.push_back(dat);
      else   qa.push_back(dat);
    end
    @(negedge Clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    bus.inValid = v;
    bus.sel     = s;
    bus.inData  = d;
  endtask

  initial begin
    drive(1'b0, SEL_A, '0);
    bus.outAReady = 1'b0;
    bus.outBReady = 1'b0;

    // Reset then idle
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_in_ready", bus.inReady, 1'b1);
    chk("rst_a_valid", bus.outAValid, 1'b0);
    chk("rst_count_a", bus.countA, 0);
    Rst_n = 1'b1;
    @(negedge Clk);
    #1;
    chk("idle_in_ready", bus.inReady, 1'b1);
    chk("idle_a_valid", bus.outAValid, 1'b0);
    chk("idle_b_valid", bus.outBValid, 1'b0);
    chk("idle_count_a", bus.countA, 0);
    chk("idle_count_b", bus.countB, 0);
    chk("idle_out_a", bus.outA, 0);
    chk("idle_out_b", bus.outB, 0);

    // Routing
    drive(1'b1, SEL_A, 32'hDEADBEEF);
    tick();
    #1;
    chk("route_out_a", bus.outA, 32'hDEADBEEF);
    chk("route_a_valid", bus.outAValid, 1'b1);
    chk("route_count_a", bus.countA, 1);
    chk("route_b_idle", bus.outBValid, 1'b0);
    drive(1'b1, SEL_B, 32'h12345678);
    tick();
    #1;
    chk("route_out_b", bus.outB, 32'h12345678);
    chk("route_b_valid", bus.outBValid, 1'b1);
    chk("route_count_b", bus.countB, 1);

    // Back-pressure isolation: A blocked, B still reachable
    drive(1'b0, SEL_A, '0);
    bus.outAReady = 1'b1;
    tick();                       // drain DEADBEEF
    bus.outAReady = 1'b0;
    drive(1'b1, SEL_A, 32'h1);
    tick();
    drive(1'b1, SEL_A, 32'h2);
    tick();
    drive(1'b1, SEL_A, 32'h3);
    #1;
    chk("bp_count_a", bus.countA, 2);
    chk("bp_ready_a_full", bus.inReady, 1'b0);
    drive(1'b1, SEL_B, 32'hB0);
    #1;
    chk("bp_ready_b", bus.inReady, 1'b1);
    tick();
    #1;
    chk("bp_count_b", bus.countB, 2);
    drive(1'b1, SEL_A, 32'h3);
    bus.outAReady = 1'b1;
    tick();                       // pops 0x1, full FIFO refuses 0x3
    #1;
    chk("bp_pop1_out_a", bus.outA, 32'h2);
    chk("bp_pop1_count", bus.countA, 1);
    tick();                       // pops 0x2, accepts 0x3
    #1;
    chk("bp_pop2_out_a", bus.outA, 32'h3);
    chk("bp_pop2_count", bus.countA, 1);

    // Simultaneous push and pop on A
    drive(1'b1, SEL_A, 32'hAA);
    tick();
    #1;
    chk("pp_count_a", bus.countA, 1);
    chk("pp_out_a", bus.outA, 32'hAA);

    // Drain everything
    drive(1'b0, SEL_A, '0);
    bus.outAReady = 1'b1;
    bus.outBReady = 1'b1;
    repeat (3) tick();

    // Wrap-around stream through A
    popped_a.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, SEL_A, W'(i));
      tick();
      #1;
      chk("wrap_count_le1", bus.countA <= 1, 1'b1);
    end
    drive(1'b0, SEL_A, '0);
    repeat (2) tick();
    chk("wrap_n_words", popped_a.size(), 10);
    for (int i = 0; i < 10 && i < popped_a.size(); i++)
      chk("wrap_order", popped_a[i], i);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!stalled)
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom);
      bus.outAReady = 1'($urandom_range(0, 2) == 0);
      bus.outBReady = 1'($urandom_range(0, 1));
      tick();
    end

    // Async reset mid-stream
    drive(1'b0, SEL_A, '0);
    bus.outAReady = 1'b1;
    bus.outBReady = 1'b1;
    repeat (3) tick();
    bus.outAReady = 1'b0;
    bus.outBReady = 1'b0;
    drive(1'b1, SEL_A, 32'h10);
    tick();
    drive(1'b1, SEL_A, 32'h11);
    tick();
    drive(1'b1, SEL_B, 32'h20);
    tick();
    drive(1'b0, SEL_A, '0);
    #1;
    chk("mr_count_a_pre", bus.countA, 2);
    chk("mr_count_b_pre", bus.countB, 1);
    #1;
    Rst_n = 1'b0;
    #1;
    chk("mr_a_valid", bus.outAValid, 1'b0);
    chk("mr_b_valid", bus.outBValid, 1'b0);
    chk("mr_count_a", bus.countA, 0);
    chk("mr_count_b", bus.countB, 0);
    qa.delete();
    qb.delete();
    stalled = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(1'b1, SEL_B, 32'h55);
    tick();
    #1;
    chk("mr_out_b", bus.outB, 32'h55);
    chk("mr_count_b_post", bus.countB, 1);
    chk("mr_a_stays_empty", bus.outAValid, 1'b0);
    drive(1'b0, SEL_A, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux32_1to2_fifo.md
Name: demux32_1to2_fifo

Overview:
- Handshaked 1-to-2 demultiplexer for 32-bit datapath words. It is the splitting counterpart of the 2-to-1 selection muxes: one producer stream is routed to one of two consumers.
- Each output has its own small FIFO, so a stalled consumer never blocks traffic to the other output.
- Used between a producer stage, such as write-back or a memory response, and two independent sinks.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO. Must be a power of 2, at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy counters. Derived; do not override.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous reset, active-low.
- inData  input  WIDTH  producer word.
- inValid  input  1  producer has a word.
- sel  input  1  destination: 0 = A, 1 = B. Qualified by inValid.
- inReady  output  1  the FIFO selected by sel is not full.
- outA  output  WIDTH  head word of FIFO A.
- outAValid  output  1  FIFO A is not empty.
- outAReady  input  1  consumer A accepts the head word.
- outB  output  WIDTH  head word of FIFO B.
- outBValid  output  1  FIFO B is not empty.
- outBReady  input  1  consumer B accepts the head word.
- countA  output  CW  occupancy of FIFO A.
- countB  output  CW  occupancy of FIFO B.

Behaviour:
- Reset: Rst_n low asynchronously clears all pointers and counters.
  - outAValid = 0, outBValid = 0, countA = 0, countB = 0, all storage = 0, outA = 0, outB = 0.
  - inReady = 1 while in reset and after release, because both FIFOs are empty.
- Push: on a rising Clk with inValid && inReady, inData is written to FIFO[sel].
  - Exactly one FIFO is written per accepted word; the other is unaffected.
- inReady is combinational: sel ? !fullB : !fullA.
  - full = (count == DEPTH).
  - inReady does not depend on outAReady or outBReady. A full FIFO refuses a push even if it pops in the same cycle.
- Producer rule: inData and sel are held stable while inValid && !inReady. The bench asserts this rule; the RTL does not check it.
- Pop: on a rising Clk with outXValid && outXReady, the read pointer of FIFO X advances.
  - outXReady while outXValid = 0 is ignored.
- Latency: a word accepted at edge N drives outX with outXValid = 1 after edge N, provided FIFO X was empty. This is 1 cycle with no bypass.
- Head data: outX = storage[rdptr].
  - When outXValid = 0, outX holds the last storage value and is not checked.
- Push and pop on the same FIFO in the same cycle (only possible when not full): the count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count saturates at no value; overflow and underflow are impossible by construction.
- Ordering: per-output FIFO order is preserved. No ordering is defined between A and B.
- Reset mid-operation: all queued words are discarded immediately, with no drain.
  - After Rst_n rises, the first push behaves as from a clean reset.
- No state machine beyond the FIFO pointers and counters. Storage is reset to 0 so simulation output is deterministic.

Decomposition:
- Shared include: default WIDTH (32) and DEPTH (2) constants, plus the sel encodings SEL_A = 1'b0 and SEL_B = 1'b1.
- One sub-module, sync_fifo_hs.
  - Parameters WIDTH and DEPTH.
  - Ports: Clk, Rst_n, wrEn, wrData, full, rdEn, rdData, empty, count.
  - Instantiated twice, for A and B. The top level contains only the steering logic and the inReady/valid mapping.

Test Plan:
- Reset then idle: Rst_n=0 for 2 cycles, then release. Check inReady=1, outAValid=0, outBValid=0, countA=0, countB=0, outA=0, outB=0.
- Routing: push 0xDEADBEEF with sel=0, then 0x12345678 with sel=1.
  - After the first edge: outA=0xDEADBEEF, outAValid=1, countA=1.
  - After the second edge: outB=0x12345678, outBValid=1, countB=1.
- Back-pressure isolation: outAReady=0, push 3 words to A (0x1, 0x2, 0x3).
  - After two accepted words, countA=2 and inReady=0 while sel=0.
  - Switching sel=1 raises inReady=1, and 0xB0 reaches B.
  - Raising outAReady pops A in order 0x1, 0x2, then 0x3 is accepted.
- Simultaneous push and pop: A holds 1 word, push 0xAA to A while outAReady=1. Check countA stays 1 and outA=0xAA after the edge.
- Wrap-around: stream 10 words 0x0 to 0x9 through A with outAReady=1 continuously. Check in-order output, no loss, and countA ≤ 1 throughout.
- Async reset mid-stream: with countA=2 and countB=1, pulse Rst_n low between edges.
  - outAValid=0, outBValid=0, countA=0, countB=0 immediately, not waiting for Clk.
  - The next push of 0x55 to B appears alone on outB.
